wr_req_arbiter: RTL and testbench

Per-slave-port write-request arbiter of the cross-bar. One instance sits downstream of the master-side write-request channels (sel/addr/wdata/req) and serves the single cross-bar output port numbered SLAVE_ID. It picks, round-robin, among masters whose `sel` equals SLAVE_ID and registers the winner's address and data onto the slave side. It holds the transfer until the slave acknowledges, then returns a one-cycle acknowledge to the winning master.

---
 rtl/xbar_pkg.sv | 29 ++
 rtl/wr_req_arbiter_if.sv | 35 +++
 rtl/wr_req_arbiter_rr_arbiter.sv | 22 ++
 rtl/wr_req_arbiter.sv | 131 +++++++++++++
 tb/tb_wr_req_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_pkg.sv
// Shared cross-bar types and the round-robin next-grant helper.
// rr_next supports up to RR_MAX requesters; callers zero-extend narrower masks.
package xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    localparam int RR_MAX = 16;
    localparam int RR_IW  = 4;

    // Smallest offset wins, so the scan runs from the farthest position inward.
    // Positions at or above the real requester count are always zero in req_vec,
    // which makes wrapping modulo RR_MAX equivalent to wrapping modulo MASTER_NUM.
    function automatic logic [RR_IW-1:0] rr_next(input logic [RR_MAX-1:0] req_vec,
                                                 input logic [RR_IW-1:0]  ptr);
        logic [RR_IW-1:0] idx;
        logic [RR_IW-1:0] grant;
        grant = ptr;
        for (int i = RR_MAX; i >= 1; i--) begin
            idx = ptr + RR_IW'(i);
            if (req_vec[idx]) grant = idx;
        end
        return grant;
    endfunction

endpackage

// File: rtl/wr_req_arbiter_if.sv
// Master-side write-request channels and the single slave-side port of one cross-bar output.
interface wr_req_arbiter_if #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int MASTER_NUM = 2,
    parameter int SLAVE_NUM  = 2
);
    localparam int SW = $clog2(SLAVE_NUM);
    localparam int IW = $clog2(MASTER_NUM);

    logic [MASTER_NUM*SW-1:0]     m_sel;
    logic [MASTER_NUM*AWIDTH-1:0] m_addr;
    logic [MASTER_NUM*DWIDTH-1:0] m_wdata;
    logic [MASTER_NUM-1:0]        m_req;
    logic [MASTER_NUM-1:0]        m_ack;
    logic [MASTER_NUM-1:0]        m_err;
    logic [AWIDTH-1:0]            s_addr;
    logic [DWIDTH-1:0]            s_wdata;
    logic                         s_req;
    logic [IW-1:0]                s_src;
    logic                         s_ack;

    // Arbiter view
    modport slave (
        input  m_sel, m_addr, m_wdata, m_req, s_ack,
        output m_ack, m_err, s_addr, s_wdata, s_req, s_src
    );

    // Environment view (masters plus downstream slave)
    modport master (
        output m_sel, m_addr, m_wdata, m_req, s_ack,
        input  m_ack, m_err, s_addr, s_wdata, s_req, s_src
    );

endinterface

// File: rtl/wr_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set bit of mask strictly after ptr, wrapping.
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter int MASTER_NUM = 2,
    parameter int IW         = 1
) (
    input  logic [MASTER_NUM-1:0] mask,
    input  logic [IW-1:0]         ptr,
    output logic                  valid,
    output logic [IW-1:0]         idx
);

    logic [RR_MAX-1:0] mask_ext;
    logic [RR_IW-1:0]  grant_ext;

    assign mask_ext  = RR_MAX'(mask);
    assign grant_ext = rr_next(mask_ext, RR_IW'(ptr));
    assign valid     = |mask;
    assign idx       = IW'(grant_ext);

endmodule

// File: rtl/wr_req_arbiter.sv
// Per-output-port write-request arbiter: round-robin grant, registered slave request, one-cycle ack.
// Optional wait-for-ack timeout enabled by defining WR_REQ_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transfer; grant next eligible master, latch its addr/wdata
// REQ   | s_req high, waiting for s_ack (or timeout); master inputs ignored
// ACK   | one-cycle m_ack (and m_err on timeout) to the granted master
module wr_req_arbiter
    import xbar_pkg::*;
#(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int MASTER_NUM = 2,
    parameter int SLAVE_NUM  = 2,
    parameter int SLAVE_ID   = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic             aclk,
    input  logic             aresetn,
    wr_req_arbiter_if.slave  bus
);

    localparam int SW = $clog2(SLAVE_NUM);
    localparam int IW = $clog2(MASTER_NUM);

    arb_state_t              state;
    logic [IW-1:0]           rr_ptr;
    logic [MASTER_NUM-1:0]   eligible;
    logic [AWIDTH-1:0]       addr_arr [MASTER_NUM];
    logic [DWIDTH-1:0]       data_arr [MASTER_NUM];
    logic                    grant_valid;
    logic [IW-1:0]           grant_idx;

    logic [AWIDTH-1:0]       addr_q;
    logic [DWIDTH-1:0]       data_q;
    logic [IW-1:0]           src_q;
    logic                    req_q;
    logic [MASTER_NUM-1:0]   ack_q;

    always_comb begin
        for (int i = 0; i < MASTER_NUM; i++) begin
            eligible[i] = bus.m_req[i] && (bus.m_sel[i*SW +: SW] == SW'(SLAVE_ID));
            addr_arr[i] = bus.m_addr[i*AWIDTH +: AWIDTH];
            data_arr[i] = bus.m_wdata[i*DWIDTH +: DWIDTH];
        end
    end

    rr_arbiter #(
        .MASTER_NUM (MASTER_NUM),
        .IW         (IW)
    ) u_rr (
        .mask  (eligible),
        .ptr   (rr_ptr),
        .valid (grant_valid),
        .idx   (grant_idx)
    );

`ifdef WR_REQ_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0]         tmo_cnt;
    logic [MASTER_NUM-1:0] err_q;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            rr_ptr <= IW'(MASTER_NUM - 1);
            addr_q <= '0;
            data_q <= '0;
            src_q  <= '0;
            req_q  <= 1'b0;
            ack_q  <= '0;
`ifdef WR_REQ_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
            err_q   <= '0;
`endif
        end else begin
            ack_q <= '0;
`ifdef WR_REQ_ARB_TIMEOUT_EN
            err_q <= '0;
`endif
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        addr_q <= addr_arr[grant_idx];
                        data_q <= data_arr[grant_idx];
                        src_q  <= grant_idx;
                        rr_ptr <= grant_idx;
                        req_q  <= 1'b1;
                        state  <= REQ;
`ifdef WR_REQ_ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus.s_ack) begin
                        req_q        <= 1'b0;
                        ack_q[src_q] <= 1'b1;
                        state        <= ACK;
                    end
`ifdef WR_REQ_ARB_TIMEOUT_EN
                    // s_ack takes priority over an expiry on the same edge.
                    else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        req_q        <= 1'b0;
                        ack_q[src_q] <= 1'b1;
                        err_q[src_q] <= 1'b1;
                        state        <= ACK;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = data_q;
    assign bus.s_src   = src_q;
    assign bus.s_req   = req_q;
    assign bus.m_ack   = ack_q;
`ifdef WR_REQ_ARB_TIMEOUT_EN
    assign bus.m_err   = err_q;
`else
    assign bus.m_err   = '0;
`endif

endmodule

// File: tb/tb_wr_req_arbiter.sv
// Self-checking bench for wr_req_arbiter: vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_wr_req_arbiter;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    wr_req_arbiter_if #(.AWIDTH(32), .DWIDTH(32), .MASTER_NUM(2), .SLAVE_NUM(2)) bus ();

    wr_req_arbiter #(
        .AWIDTH(32), .DWIDTH(32), .MASTER_NUM(2), .SLAVE_NUM(2), .SLAVE_ID(0), .TIMEOUT(4)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  sel;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] data0;
        logic [31:0] data1;
        logic        exp_valid;
        int          exp_src;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drop_inputs();
        bus.m_req   = 2'b00;
        bus.m_sel   = 2'b00;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        int          grants [$];
        int          gcyc   [$];
        logic        prev_req;
        // random-model state
        int          last_g;
        int          g;
        int          free_edge;
        int          req_cycles;
        bit          in_req;
        bit          sack;
        logic [1:0]  held_req;
        logic [1:0]  held_sel;
        logic [31:0] held_addr [2];
        logic [31:0] held_data [2];
        logic [1:0]  elig;
        logic [1:0]  exp_ack;

        tbl[0] = '{2'b01, 2'b00, 32'h10,  32'h0,   32'hA5,  32'h0,   1'b1, 0};
        tbl[1] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h111, 32'h222, 1'b1, 1};
        tbl[2] = '{2'b11, 2'b00, 32'h104, 32'h204, 32'h333, 32'h444, 1'b1, 0};
        tbl[3] = '{2'b11, 2'b00, 32'h108, 32'h208, 32'h555, 32'h666, 1'b1, 1};
        tbl[4] = '{2'b10, 2'b10, 32'h0,   32'h300, 32'h0,   32'h777, 1'b0, 0};
        tbl[5] = '{2'b11, 2'b01, 32'h400, 32'h500, 32'h888, 32'h999, 1'b1, 1};
        tbl[6] = '{2'b01, 2'b00, 32'h600, 32'h0,   32'hAAA, 32'h0,   1'b1, 0};
        tbl[7] = '{2'b10, 2'b00, 32'h0,   32'h700, 32'h0,   32'hBBB, 1'b1, 1};
        tbl[8] = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 0};

        drop_inputs();
        aresetn = 1'b0;
        tick();
        tick();
        check("rst_s_req",  64'(bus.s_req),  64'(0));
        check("rst_m_ack",  64'(bus.m_ack),  64'(0));
        check("rst_m_err",  64'(bus.m_err),  64'(0));
        check("rst_s_addr", 64'(bus.s_addr), 64'(0));
        check("rst_s_src",  64'(bus.s_src),  64'(0));
        aresetn = 1'b1;

        // Vector table: one arbitration each, slave acks on the first REQ cycle.
        for (int v = 0; v < 9; v++) begin
            bus.m_req   = tbl[v].req;
            bus.m_sel   = tbl[v].sel;
            bus.m_addr  = {tbl[v].addr1, tbl[v].addr0};
            bus.m_wdata = {tbl[v].data1, tbl[v].data0};
            tick();
            check("tbl_s_req", 64'(bus.s_req), 64'(tbl[v].exp_valid));
            if (tbl[v].exp_valid) begin
                exp_addr = (tbl[v].exp_src == 0) ? tbl[v].addr0 : tbl[v].addr1;
                exp_data = (tbl[v].exp_src == 0) ? tbl[v].data0 : tbl[v].data1;
                check("tbl_s_src",   64'(bus.s_src),   64'(tbl[v].exp_src));
                check("tbl_s_addr",  64'(bus.s_addr),  64'(exp_addr));
                check("tbl_s_wdata", 64'(bus.s_wdata), 64'(exp_data));
                bus.s_ack = 1'b1;
                tick();
                bus.s_ack = 1'b0;
                check("tbl_m_ack",     64'(bus.m_ack), 64'(2'b01 << tbl[v].exp_src));
                check("tbl_ack_s_req", 64'(bus.s_req), 64'(0));
                check("tbl_m_err",     64'(bus.m_err), 64'(0));
                check("tbl_ack_src",   64'(bus.s_src), 64'(tbl[v].exp_src));
                bus.m_req = 2'b00;
                tick();
                check("tbl_ack_gone", 64'(bus.m_ack), 64'(0));
            end else begin
                bus.m_req = 2'b00;
                tick();
                check("tbl_idle_s_req", 64'(bus.s_req), 64'(0));
                check("tbl_idle_m_ack", 64'(bus.m_ack), 64'(0));
            end
        end

        // Filtering: master 1 targets the other port for 20 cycles.
        bus.m_req   = 2'b10;
        bus.m_sel   = 2'b10;
        bus.m_addr  = {32'hDEAD0000, 32'h0};
        for (int c = 0; c < 20; c++) begin
            bus.s_ack = 1'($urandom_range(0, 1));
            tick();
            check("filt_s_req", 64'(bus.s_req), 64'(0));
            check("filt_m_ack", 64'(bus.m_ack), 64'(0));
        end
        drop_inputs();
        tick();

`ifndef WR_REQ_ARB_TIMEOUT_EN
        // Stall and abandon: master drops req in REQ, slave holds off ack.
        bus.m_req   = 2'b01;
        bus.m_addr  = {32'h0, 32'h1234};
        bus.m_wdata = {32'h0, 32'hBEEF};
        tick();
        bus.m_req   = 2'b00;
        bus.m_addr  = {32'h0, 32'h5555};
        bus.m_wdata = {32'h0, 32'h6666};
        for (int c = 1; c <= 10; c++) begin
            check("stall_s_req",   64'(bus.s_req),   64'(1));
            check("stall_s_addr",  64'(bus.s_addr),  64'(32'h1234));
            check("stall_s_wdata", 64'(bus.s_wdata), 64'(32'hBEEF));
            check("stall_m_ack",   64'(bus.m_ack),   64'(0));
            bus.s_ack = (c == 10);
            tick();
        end
        bus.s_ack = 1'b0;
        check("stall_ack",      64'(bus.m_ack), 64'(2'b01));
        check("stall_s_req_lo", 64'(bus.s_req), 64'(0));
        tick();
        check("stall_ack_gone", 64'(bus.m_ack), 64'(0));
`else
        // Timeout: no ack for 4 REQ cycles, then ack and err together.
        bus.m_req  = 2'b01;
        bus.m_addr = {32'h0, 32'h44};
        tick();
        for (int c = 1; c <= 4; c++) begin
            check("tmo_s_req", 64'(bus.s_req), 64'(1));
            check("tmo_m_err", 64'(bus.m_err), 64'(0));
            tick();
        end
        check("tmo_m_ack",    64'(bus.m_ack), 64'(2'b01));
        check("tmo_m_err_hi", 64'(bus.m_err), 64'(2'b01));
        check("tmo_s_req_lo", 64'(bus.s_req), 64'(0));
        bus.m_req = 2'b00;
        tick();
        check("tmo_ack_gone", 64'(bus.m_ack), 64'(0));
        check("tmo_err_gone", 64'(bus.m_err), 64'(0));
        // Ack on the 4th REQ cycle beats the timeout.
        bus.m_req = 2'b01;
        tick();
        for (int c = 1; c <= 4; c++) begin
            check("tmo2_s_req", 64'(bus.s_req), 64'(1));
            bus.s_ack = (c == 4);
            tick();
        end
        bus.s_ack = 1'b0;
        check("tmo2_m_ack", 64'(bus.m_ack), 64'(2'b01));
        check("tmo2_m_err", 64'(bus.m_err), 64'(0));
        bus.m_req = 2'b00;
        tick();
`endif

        // Reset mid-transfer.
        bus.m_req   = 2'b10;
        bus.m_addr  = {32'hCAFE0000, 32'h0};
        bus.m_wdata = {32'h12345678, 32'h0};
        tick();
        check("mid_s_req_before", 64'(bus.s_req), 64'(1));
        #2 aresetn = 1'b0;
        #1;
        check("mid_rst_s_req",  64'(bus.s_req),  64'(0));
        check("mid_rst_s_addr", 64'(bus.s_addr), 64'(0));
        check("mid_rst_s_src",  64'(bus.s_src),  64'(0));
        check("mid_rst_m_ack",  64'(bus.m_ack),  64'(0));
        drop_inputs();
        @(posedge aclk);
        #3 aresetn = 1'b1;

        // Fairness: both masters request continuously, slave always ready.
        bus.m_req   = 2'b11;
        bus.m_sel   = 2'b00;
        bus.m_addr  = {32'hB0, 32'hA0};
        bus.m_wdata = {32'hB1, 32'hA1};
        bus.s_ack   = 1'b1;
        prev_req    = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.s_req && !prev_req) begin
                grants.push_back(int'(bus.s_src));
                gcyc.push_back(c);
            end
            prev_req = bus.s_req;
        end
        drop_inputs();
        check("fair_grant_count", 64'(grants.size()), 64'(4));
        for (int k = 0; k < grants.size(); k++) begin
            check("fair_grant_order", 64'(grants[k]), 64'(k % 2));
            if (k > 0) check("fair_grant_gap", 64'(gcyc[k] - gcyc[k-1]), 64'(3));
        end
        tick();
        tick();

        // Randomized run against a transaction-level model.
        aresetn = 1'b0;
        tick();
        aresetn    = 1'b1;
        last_g     = 1;
        g          = 0;
        free_edge  = 0;
        req_cycles = 0;
        in_req     = 1'b0;
        held_req   = 2'b00;
        held_sel   = 2'b00;
        exp_addr   = '0;
        exp_data   = '0;
        for (int i = 0; i < 2; i++) begin
            held_addr[i] = '0;
            held_data[i] = '0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!held_req[i] && $urandom_range(0, 3) == 0) begin
                    held_req[i]  = 1'b1;
                    held_sel[i]  = 1'($urandom_range(0, 1));
                    held_addr[i] = $urandom;
                    held_data[i] = $urandom;
                end
            end
            bus.m_req   = held_req;
            bus.m_sel   = held_sel;
            bus.m_addr  = {held_req[1] ? held_addr[1] : 32'($urandom),
                           held_req[0] ? held_addr[0] : 32'($urandom)};
            bus.m_wdata = {held_req[1] ? held_data[1] : 32'($urandom),
                           held_req[0] ? held_data[0] : 32'($urandom)};
            elig = held_req & ~held_sel;
            sack = in_req ? (req_cycles >= 3 || $urandom_range(0, 2) == 0)
                          : ($urandom_range(0, 1) == 1);
            bus.s_ack = sack;
            tick();

            exp_ack = 2'b00;
            if (in_req) begin
                if (sack) begin
                    in_req     = 1'b0;
                    exp_ack[g] = 1'b1;
                    free_edge  = cyc + 2;
                end else begin
                    req_cycles++;
                end
            end else if (cyc >= free_edge && elig != 2'b00) begin
                for (int k = 2; k >= 1; k--)
                    if (elig[(last_g + k) % 2]) g = (last_g + k) % 2;
                last_g     = g;
                in_req     = 1'b1;
                req_cycles = 0;
                exp_addr   = held_addr[g];
                exp_data   = held_data[g];
            end

            check("rnd_s_req", 64'(bus.s_req), 64'(in_req));
            check("rnd_m_ack", 64'(bus.m_ack), 64'(exp_ack));
            check("rnd_m_err", 64'(bus.m_err), 64'(0));
            if (in_req || exp_ack != 2'b00) begin
                check("rnd_s_src",   64'(bus.s_src),   64'(g));
                check("rnd_s_addr",  64'(bus.s_addr),  64'(exp_addr));
                check("rnd_s_wdata", 64'(bus.s_wdata), 64'(exp_data));
            end

            for (int i = 0; i < 2; i++) begin
                if (held_req[i] && bus.m_ack[i])
                    held_req[i] = 1'b0;
                else if (held_req[i] && held_sel[i] && $urandom_range(0, 3) == 0)
                    held_req[i] = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
